// File: rtl/multicycle_ctrl_if.sv
// Fetch handshake, memory-ready and datapath control-strobe bundle for multicycle_ctrl.
interface multicycle_ctrl_if;
  logic       instr_valid;
  logic       instr_ready;
  logic [6:0] opcode;
  logic [2:0] funct3;
  logic [6:0] funct7;
  logic       mem_ready;
  logic [1:0] ALUSrc;
  logic [4:0] ALUOp;
  logic       Branch;
  logic       MemRead;
  logic       MemWrite;
  logic       MemToReg;
  logic       RegWrite;
  logic       PCWrite;
  logic       IllegalInstr;
  logic       busy;

  modport master (
    output instr_valid, opcode, funct3, funct7, mem_ready,
    input  instr_ready, ALUSrc, ALUOp, Branch, MemRead, MemWrite,
           MemToReg, RegWrite, PCWrite, IllegalInstr, busy
  );

  modport slave (
    input  instr_valid, opcode, funct3, funct7, mem_ready,
    output instr_ready, ALUSrc, ALUOp, Branch, MemRead, MemWrite,
           MemToReg, RegWrite, PCWrite, IllegalInstr, busy
  );
endinterface

// File: rtl/multicycle_ctrl.sv
// Multi-cycle RV32I(+M) control FSM: accepts one decoded instruction per handshake and
// sequences EXEC/MEM/MULDIV/WB phases, driving datapath strobes from state and instr register.
module multicycle_ctrl #(
  parameter bit ENABLE_M = 1'b1,
  parameter int MUL_LAT  = 3,
  parameter int DIV_LAT  = 32
) (
  input logic              clk,
  input logic              rst,
  multicycle_ctrl_if.slave bus
);
  localparam int MAX_LAT = (MUL_LAT > DIV_LAT) ? MUL_LAT : DIV_LAT;
  localparam int CW      = $clog2(MAX_LAT + 1);

  localparam logic [6:0] OP_R      = 7'b0110011;
  localparam logic [6:0] OP_IMM    = 7'b0010011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;

  typedef enum logic [2:0] {S_FETCH, S_EXEC, S_MEM, S_MULDIV, S_WB, S_TRAP} state_t;
  typedef enum logic [2:0] {K_ALU, K_LOAD, K_STORE, K_BRANCH, K_MUL, K_DIV} kind_t;
  typedef struct packed {
    kind_t      kind;
    logic [4:0] aluop;
    logic [1:0] alusrc;
  } dec_t;

  state_t        state, state_next;
  logic [CW-1:0] cnt, cnt_next;
  logic [6:0]    op_q;
  logic [2:0]    f3_q;
  logic [6:0]    f7_q;
  logic          legal_in;
  dec_t          dec_q;

  function automatic logic legal_instr(input logic [6:0] op, input logic [2:0] f3,
                                       input logic [6:0] f7);
    case (op)
      OP_R:      return (f7 == 7'b0000000) ||
                        (f7 == 7'b0100000 && (f3 == 3'b000 || f3 == 3'b101)) ||
                        (f7 == 7'b0000001 && ENABLE_M);
      OP_IMM:    return (f3 == 3'b001) ? (f7 == 7'b0000000) :
                        (f3 == 3'b101) ? (f7 == 7'b0000000 || f7 == 7'b0100000) : 1'b1;
      OP_LOAD:   return f3 != 3'b011 && f3 != 3'b110 && f3 != 3'b111;
      OP_STORE:  return f3 == 3'b000 || f3 == 3'b001 || f3 == 3'b010;
      OP_BRANCH: return f3 != 3'b010 && f3 != 3'b011;
      OP_JALR:   return f3 == 3'b000;
      OP_JAL, OP_LUI, OP_AUIPC: return 1'b1;
      default:   return 1'b0;
    endcase
  endfunction

  // alt selects SUB/SRA; it only has meaning for funct3 000 and 101
  function automatic logic [4:0] base_op(input logic [2:0] f3, input logic alt);
    case (f3)
      3'b000:  return alt ? 5'd1 : 5'd0;
      3'b001:  return 5'd5;
      3'b010:  return 5'd8;
      3'b011:  return 5'd9;
      3'b100:  return 5'd4;
      3'b101:  return alt ? 5'd7 : 5'd6;
      3'b110:  return 5'd3;
      default: return 5'd2;
    endcase
  endfunction

  // Only ever applied to an instruction that already passed legal_instr
  function automatic dec_t decode(input logic [6:0] op, input logic [2:0] f3,
                                  input logic [6:0] f7);
    dec_t d;
    d.kind   = K_ALU;
    d.aluop  = 5'd0;
    d.alusrc = 2'b01;
    case (op)
      OP_R: begin
        d.alusrc = 2'b00;
        if (f7[0]) begin
          d.kind  = f3[2] ? K_DIV : K_MUL;
          d.aluop = 5'd10 + {2'b00, f3};
        end else begin
          d.aluop = base_op(f3, f7[5]);
        end
      end
      OP_IMM:   d.aluop = base_op(f3, (f3 == 3'b101) && f7[5]);
      OP_LOAD:  d.kind = K_LOAD;
      OP_STORE: d.kind = K_STORE;
      OP_BRANCH: begin
        d.kind   = K_BRANCH;
        d.aluop  = 5'd1;
        d.alusrc = 2'b00;
      end
      default: ;
    endcase
    return d;
  endfunction

  assign legal_in = legal_instr(bus.opcode, bus.funct3, bus.funct7);
  assign dec_q    = decode(op_q, f3_q, f7_q);

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= S_FETCH;
      cnt   <= '0;
      op_q  <= '0;
      f3_q  <= '0;
      f7_q  <= '0;
    end else begin
      state <= state_next;
      cnt   <= cnt_next;
      if (state == S_FETCH && bus.instr_valid) begin
        op_q <= bus.opcode;
        f3_q <= bus.funct3;
        f7_q <= bus.funct7;
      end
    end
  end

  always_comb begin
    state_next = state;
    cnt_next   = cnt;
    case (state)
      S_FETCH: if (bus.instr_valid) state_next = legal_in ? S_EXEC : S_TRAP;
      S_EXEC: begin
        case (dec_q.kind)
          K_LOAD, K_STORE: state_next = S_MEM;
          K_BRANCH:        state_next = S_FETCH;
          K_MUL: begin
            state_next = S_MULDIV;
            cnt_next   = CW'(MUL_LAT - 1);
          end
          K_DIV: begin
            state_next = S_MULDIV;
            cnt_next   = CW'(DIV_LAT - 1);
          end
          default:         state_next = S_WB;
        endcase
      end
      S_MEM:    if (bus.mem_ready) state_next = (dec_q.kind == K_LOAD) ? S_WB : S_FETCH;
      S_MULDIV: begin
        if (cnt == '0) state_next = S_WB;
        else           cnt_next   = cnt - CW'(1);
      end
      default:  state_next = S_FETCH;
    endcase
  end

  // A store retires in the same cycle memory acknowledges, hence the mem_ready term on PCWrite
  always_comb begin
    bus.instr_ready  = 1'b0;
    bus.ALUSrc       = 2'b00;
    bus.ALUOp        = 5'd0;
    bus.Branch       = 1'b0;
    bus.MemRead      = 1'b0;
    bus.MemWrite     = 1'b0;
    bus.MemToReg     = 1'b0;
    bus.RegWrite     = 1'b0;
    bus.PCWrite      = 1'b0;
    bus.IllegalInstr = 1'b0;
    bus.busy         = 1'b0;
    if (!rst) begin
      bus.busy = (state != S_FETCH);
      case (state)
        S_FETCH: bus.instr_ready = 1'b1;
        S_EXEC: begin
          bus.ALUSrc = dec_q.alusrc;
          bus.ALUOp  = dec_q.aluop;
          if (dec_q.kind == K_BRANCH) begin
            bus.Branch  = 1'b1;
            bus.PCWrite = 1'b1;
          end
        end
        S_MEM: begin
          bus.ALUSrc   = dec_q.alusrc;
          bus.ALUOp    = dec_q.aluop;
          bus.MemRead  = (dec_q.kind == K_LOAD);
          bus.MemWrite = (dec_q.kind == K_STORE);
          bus.PCWrite  = (dec_q.kind == K_STORE) && bus.mem_ready;
        end
        S_MULDIV: bus.ALUOp = dec_q.aluop;
        S_WB: begin
          bus.ALUOp    = dec_q.aluop;
          bus.RegWrite = 1'b1;
          bus.PCWrite  = 1'b1;
          bus.MemToReg = (dec_q.kind == K_LOAD);
        end
        S_TRAP:  bus.IllegalInstr = 1'b1;
        default: ;
      endcase
    end
  end
endmodule
